// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store controller driving pulsed data-memory enables and a one-cycle writeback packet.
// Optional alignment trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [2:0]        dm_load_format,
    output logic [1:0]        dm_store_format,
    output logic              dm_read_en,
    output logic              dm_write_en,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [63:0]       dm_wdata,
    input  logic [63:0]       dm_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [63:0]       wb_data,
    output logic              wb_reg_write,
    output logic              wb_misaligned
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [2:0] f3;
    logic [4:0] rd;
    logic is_ld;
    logic is_mem;
    logic illegal;
    logic mis;
    logic [63:0] ext;
    assign req_ready = state == IDLE;
    assign is_mem = req_is_load || req_is_store;
    assign illegal = (req_is_load && req_is_store) || (req_is_load && req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = is_mem && !illegal && (req_funct3[1:0] == 2'd1 ? req_addr[0] :
                                        req_funct3[1:0] == 2'd2 ? |req_addr[1:0] :
                                        req_funct3[1:0] == 2'd3 ? |req_addr[2:0] : 1'b0);
`else
    assign mis = 1'b0;
`endif
    // sign/zero-extend the access-sized low part of the read data, discarding stale upper bytes
    always_comb begin
        ext = f3[1:0] == 2'd0 ? {{56{!f3[2] && dm_rdata[7]}}, dm_rdata[7:0]} :
              f3[1:0] == 2'd1 ? {{48{!f3[2] && dm_rdata[15]}}, dm_rdata[15:0]} :
              f3[1:0] == 2'd2 ? {{32{!f3[2] && dm_rdata[31]}}, dm_rdata[31:0]} : dm_rdata;
    end
    // request FSM with registered memory and writeback outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            f3 <= '0;
            rd <= '0;
            is_ld <= 1'b0;
            dm_load_format <= '0;
            dm_store_format <= '0;
            dm_read_en <= 1'b0;
            dm_write_en <= 1'b0;
            dm_addr <= '0;
            dm_wdata <= '0;
            wb_valid <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
            wb_reg_write <= 1'b0;
            wb_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    if (req_valid) begin
                        f3 <= req_funct3;
                        rd <= req_rd;
                        is_ld <= req_is_load;
                        if (!is_mem || illegal || mis) begin
                            state <= DONE;
                            wb_valid <= 1'b1;
                            wb_rd <= req_rd;
                            wb_data <= 64'(req_addr);
                            wb_reg_write <= !is_mem && req_rd != 5'd0;
                            wb_misaligned <= mis;
                        end else begin
                            state <= ISSUE;
                            dm_read_en <= req_is_load;
                            dm_write_en <= req_is_store;
                            dm_addr <= req_addr;
                            dm_wdata <= req_wdata;
                            dm_load_format <= req_funct3[1:0] == 2'd3 ? 3'b101 : {1'b0, req_funct3[1:0]};
                            dm_store_format <= req_funct3[1:0];
                        end
                    end
                end
                ISSUE: begin
                    dm_read_en <= 1'b0;
                    dm_write_en <= 1'b0;
                    cnt <= 4'(MEM_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        wb_valid <= 1'b1;
                        wb_rd <= rd;
                        wb_data <= is_ld ? ext : 64'(dm_addr);
                        wb_reg_write <= is_ld && rd != 5'd0;
                        wb_misaligned <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    wb_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
